// File: rtl/axi_sts_alert_pkg.sv
// Shared constants and helpers for the AXI4-Lite status alert bank.
// Holds control-space word offsets, AXI response codes and clogb2.
package axi_sts_alert_pkg;

    localparam int CTRL_CHANGED = 0;
    localparam int CTRL_MASK    = 1;
    localparam int CTRL_PENDING = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_sts_alert_bank_if.sv
// AXI4-Lite slave bundle for the status alert bank.
// Ports: AW/W/B write channels, AR/R read channels; master/slave modports.
interface axi_sts_alert_bank_if #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );
endinterface

// File: rtl/sts_alert_slot.sv
// Per-slot change tracker: BASELINE value plus sticky CHANGED flag.
// Ports: clk, rst, sample (slot value), rd_stb, w1c; out changed.
module sts_alert_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sample,
    input  logic         rd_stb,
    input  logic         w1c,
    output logic         changed
);
    logic [W-1:0] baseline_q, baseline_d;
    logic         changed_q, changed_d;

    // Read clear beats a set; a set beats a W1C clear.
    always_comb begin
        baseline_d = baseline_q;
        changed_d  = changed_q;
        if (rd_stb) begin
            baseline_d = sample;
            changed_d  = 1'b0;
        end else if (sample != baseline_q) begin
            changed_d = 1'b1;
        end else if (w1c) begin
            changed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baseline_q <= '0;
            changed_q  <= 1'b0;
        end else begin
            baseline_q <= baseline_d;
            changed_q  <= changed_d;
        end
    end

    assign changed = changed_q;
endmodule

// File: rtl/axi_sts_alert_bank.sv
// AXI4-Lite status bank with per-slot change flags, mask and alert.
// Ports: aclk, areset, sts_data, alert, s_axi (slave modport).
// Option: AXI_STS_ALERT_SYNC_EN adds a 2-flop sts_data synchroniser.
module axi_sts_alert_bank
    import axi_sts_alert_pkg::*;
#(
    parameter int STS_DATA_WIDTH = 1024,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [STS_DATA_WIDTH-1:0] sts_data,
    output logic                      alert,
    axi_sts_alert_bank_if.slave       s_axi
);
    localparam int W        = AXI_DATA_WIDTH;
    localparam int A        = AXI_ADDR_WIDTH;
    localparam int N        = STS_DATA_WIDTH / W;
    localparam int ADDR_LSB = clogb2(W / 8);
    localparam int IW       = A - 1 - ADDR_LSB;

    if ((STS_DATA_WIDTH % W) != 0 || N < 1 || N > W) begin : g_bad_cfg
        $error("axi_sts_alert_bank: bad STS_DATA_WIDTH/AXI_DATA_WIDTH");
    end

    logic [STS_DATA_WIDTH-1:0] sample;

`ifdef AXI_STS_ALERT_SYNC_EN
    logic [STS_DATA_WIDTH-1:0] sync1_q, sync1_d;
    logic [STS_DATA_WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = sts_data;
        sync2_d = sync1_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = sts_data;
`endif

    logic [W-1:0]   slot_data [N];
    logic [N-1:0]   changed, rd_hit, rd_stb, w1c, bit_en;
    logic [N-1:0]   mask_q, mask_d;
    logic           rvalid_q, rvalid_d;
    logic [W-1:0]   rdata_q, rdata_d;
    logic [1:0]     rresp_q, rresp_d;
    logic           aw_held_q, aw_held_d;
    logic [A-1:0]   awaddr_q, awaddr_d;
    logic           w_held_q, w_held_d;
    logic [W-1:0]   wdata_q, wdata_d;
    logic [W/8-1:0] wstrb_q, wstrb_d;
    logic           bvalid_q, bvalid_d;
    logic [1:0]     bresp_q, bresp_d;
    logic           alert_q, alert_d;
    logic           ar_hs, aw_hs, w_hs, wr_go;
    logic           rd_ok, wr_ok, rd_ctl, wr_ctl;
    logic [W-1:0]   rd_word;
    logic [IW-1:0]  rd_idx, wr_idx;
    logic           unused_bits;

    for (genvar g = 0; g < N; g++) begin : g_slot
        assign slot_data[g] = sample[g*W +: W];
        sts_alert_slot #(.W(W)) u_slot (
            .clk     (aclk),
            .rst     (areset),
            .sample  (slot_data[g]),
            .rd_stb  (rd_stb[g]),
            .w1c     (w1c[g]),
            .changed (changed[g])
        );
    end

    assign s_axi.arready = !rvalid_q;
    assign s_axi.awready = !aw_held_q && !bvalid_q;
    assign s_axi.wready  = !w_held_q && !bvalid_q;
    assign ar_hs  = s_axi.arvalid && s_axi.arready;
    assign aw_hs  = s_axi.awvalid && s_axi.awready;
    assign w_hs   = s_axi.wvalid && s_axi.wready;
    assign wr_go  = aw_held_q && w_held_q;
    assign rd_ctl = s_axi.araddr[A-1];
    assign rd_idx = s_axi.araddr[ADDR_LSB +: IW];
    assign wr_ctl = awaddr_q[A-1];
    assign wr_idx = awaddr_q[ADDR_LSB +: IW];
    assign rd_stb = rd_hit & {N{ar_hs}};
    assign unused_bits = ^{s_axi.araddr, awaddr_q, wdata_q, wstrb_q};

    always_comb begin
        rd_ok   = 1'b0;
        rd_word = '0;
        rd_hit  = '0;
        if (!rd_ctl) begin
            for (int i = 0; i < N; i++) begin
                if (rd_idx == IW'(i)) begin
                    rd_ok     = 1'b1;
                    rd_word   = slot_data[i];
                    rd_hit[i] = 1'b1;
                end
            end
        end else begin
            unique case (1'b1)
                (rd_idx == IW'(CTRL_CHANGED)): begin
                    rd_ok   = 1'b1;
                    rd_word = W'(changed);
                end
                (rd_idx == IW'(CTRL_MASK)): begin
                    rd_ok   = 1'b1;
                    rd_word = W'(mask_q);
                end
                (rd_idx == IW'(CTRL_PENDING)): begin
                    rd_ok   = 1'b1;
                    rd_word = W'(changed & mask_q);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bit_en[i] = wstrb_q[i/8];
        end
    end

    // Held write is decoded every cycle but only commits on wr_go.
    always_comb begin
        wr_ok  = 1'b0;
        w1c    = '0;
        mask_d = mask_q;
        if (wr_ctl) begin
            unique case (1'b1)
                (wr_idx == IW'(CTRL_CHANGED)): begin
                    wr_ok = 1'b1;
                    w1c   = wdata_q[N-1:0] & bit_en & {N{wr_go}};
                end
                (wr_idx == IW'(CTRL_MASK)): begin
                    wr_ok = 1'b1;
                    if (wr_go) begin
                        mask_d = (mask_q & ~bit_en)
                               | (wdata_q[N-1:0] & bit_en);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        alert_d   = |(changed & mask_q);
        if (rvalid_q && s_axi.rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi.awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.wdata;
            wstrb_d  = s_axi.wstrb;
        end
        if (wr_go) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
        if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            mask_q    <= '1;
            alert_q   <= 1'b0;
        end else begin
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            mask_q    <= mask_d;
            alert_q   <= alert_d;
        end
    end

    assign s_axi.rvalid = rvalid_q;
    assign s_axi.rdata  = rdata_q;
    assign s_axi.rresp  = rresp_q;
    assign s_axi.bvalid = bvalid_q;
    assign s_axi.bresp  = bresp_q;
    assign alert        = alert_q;
endmodule

// File: tb/tb_axi_sts_alert_bank.sv
// Self-checking bench for axi_sts_alert_bank.
// Transaction-level reference model of CHANGED/MASK/BASELINE.
module tb_axi_sts_alert_bank;
    import axi_sts_alert_pkg::*;

    localparam int SW = 1024;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int N  = SW / DW;
`ifdef AXI_STS_ALERT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam logic [AW-1:0] A_CHG  = 16'h8000;
    localparam logic [AW-1:0] A_MASK = 16'h8004;
    localparam logic [AW-1:0] A_PEND = 16'h8008;
    localparam logic [AW-1:0] A_BAD  = 16'h800C;

    logic          aclk = 1'b0;
    logic          areset;
    logic [SW-1:0] sts_data;
    logic          alert;

    axi_sts_alert_bank_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) s_axi ();

    axi_sts_alert_bank #(
        .STS_DATA_WIDTH(SW), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .sts_data (sts_data),
        .alert    (alert),
        .s_axi    (s_axi)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_sts  [N];
    logic [DW-1:0] m_base [N];
    logic [N-1:0]  m_chg;
    logic [N-1:0]  m_mask;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic set_slot(input int i, input logic [DW-1:0] v);
        m_sts[i] = v;
        sts_data[i*DW +: DW] = v;
    endtask

    task automatic model_mark();
        for (int i = 0; i < N; i++) begin
            if (m_sts[i] !== m_base[i]) m_chg[i] = 1'b1;
        end
    endtask

    task automatic settle();
        tick(3 + SYNC_LAT);
        model_mark();
    endtask

    task automatic model_w1c(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        for (int i = 0; i < N; i++) begin
            if (d[i] && s[i/8]) m_chg[i] = 1'b0;
        end
        model_mark();
    endtask

    task automatic model_mask(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        for (int i = 0; i < N; i++) begin
            if (s[i/8]) m_mask[i] = d[i];
        end
    endtask

    function automatic logic model_alert();
        return |(m_chg & m_mask);
    endfunction

    function automatic logic [AW-1:0] slot_addr(input int i);
        return AW'(i * 4);
    endfunction

    task automatic axi_read(input logic [AW-1:0] addr,
                            output logic [DW-1:0] data,
                            output logic [1:0] resp);
        int   cnt;
        logic acc;
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        s_axi.rready  = 1'b1;
        acc = 1'b0;
        cnt = 0;
        while (!acc && cnt < 20) begin
            acc = s_axi.arready;
            tick(1);
            cnt++;
        end
        s_axi.arvalid = 1'b0;
        cnt = 0;
        while (!s_axi.rvalid && cnt < 20) begin
            tick(1);
            cnt++;
        end
        n_tests++;
        if (!acc || !s_axi.rvalid) begin
            n_fail++;
            $display("FAIL rd_handshake addr=%h got rvalid=%b want 1", addr, s_axi.rvalid);
            data = '0;
            resp = 2'b11;
        end else begin
            data = s_axi.rdata;
            resp = s_axi.rresp;
        end
        tick(1);
        s_axi.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr,
                             input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb,
                             output logic [1:0] resp);
        int   cnt;
        logic aw_ok, w_ok, a_hs, w_hs;
        s_axi.awaddr  = addr;
        s_axi.awvalid = 1'b1;
        s_axi.wdata   = data;
        s_axi.wstrb   = strb;
        s_axi.wvalid  = 1'b1;
        s_axi.bready  = 1'b1;
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        cnt   = 0;
        while (!(aw_ok && w_ok) && cnt < 20) begin
            a_hs = s_axi.awvalid && s_axi.awready;
            w_hs = s_axi.wvalid && s_axi.wready;
            tick(1);
            cnt++;
            if (a_hs) begin aw_ok = 1'b1; s_axi.awvalid = 1'b0; end
            if (w_hs) begin w_ok = 1'b1; s_axi.wvalid = 1'b0; end
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        cnt = 0;
        while (!s_axi.bvalid && cnt < 20) begin
            tick(1);
            cnt++;
        end
        n_tests++;
        if (!s_axi.bvalid) begin
            n_fail++;
            $display("FAIL wr_handshake addr=%h got bvalid=0 want 1", addr);
            resp = 2'b11;
        end else begin
            resp = s_axi.bresp;
        end
        tick(1);
        s_axi.bready = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        logic [1:0]    r;
        s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0;
        s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        sts_data = '0;
        for (int i = 0; i < N; i++) begin m_sts[i] = '0; m_base[i] = '0; end
        m_chg  = '0;
        m_mask = '1;
        areset = 1'b1;
        tick(2);
        areset = 1'b0;
        n_tests++; if (alert !== 1'b0) begin n_fail++; $display("FAIL rst_alert got %b want 0", alert); end
        n_tests++; if (s_axi.rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b want 0", s_axi.rvalid); end
        n_tests++; if (s_axi.bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid got %b want 0", s_axi.bvalid); end
        n_tests++; if (s_axi.rdata !== '0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", s_axi.rdata); end
        n_tests++; if (s_axi.rresp !== 2'b00 || s_axi.bresp !== 2'b00) begin n_fail++; $display("FAIL rst_resp got %b/%b want 00/00", s_axi.rresp, s_axi.bresp); end
        n_tests++; if ({s_axi.arready, s_axi.awready, s_axi.wready} !== 3'b111) begin n_fail++; $display("FAIL rst_ready got %b%b%b want 111", s_axi.arready, s_axi.awready, s_axi.wready); end
        // Write to MASK accepted, then reset lands before it commits.
        s_axi.awaddr = A_MASK; s_axi.awvalid = 1'b1;
        s_axi.wdata = '0; s_axi.wstrb = '1; s_axi.wvalid = 1'b1;
        tick(1);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        areset = 1'b1;
        tick(1);
        areset = 1'b0;
        tick(2);
        n_tests++; if (s_axi.bvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_bvalid got %b want 0", s_axi.bvalid); end
        n_tests++; if (s_axi.awready !== 1'b1) begin n_fail++; $display("FAIL midrst_awready got %b want 1", s_axi.awready); end
        axi_read(A_MASK, d, r);
        n_tests++; if (d !== DW'(m_mask) || r !== RESP_OKAY) begin n_fail++; $display("FAIL rst_mask got %h/%b want %h/00", d, r, DW'(m_mask)); end
        axi_read(A_CHG, d, r);
        n_tests++; if (d !== DW'(m_chg)) begin n_fail++; $display("FAIL rst_changed got %h want %h", d, DW'(m_chg)); end
    endtask

    task automatic test_alert_latency();
        logic [DW-1:0] d;
        logic [1:0]    r;
        set_slot(3, 32'hA5A5_0001);
        tick(1 + SYNC_LAT);
        n_tests++; if (alert !== 1'b0) begin n_fail++; $display("FAIL alert_early got %b want 0", alert); end
        tick(1);
        n_tests++; if (alert !== 1'b1) begin n_fail++; $display("FAIL alert_rise got %b want 1", alert); end
        model_mark();
        axi_read(A_CHG, d, r);
        n_tests++; if (d !== DW'(m_chg)) begin n_fail++; $display("FAIL chg_slot3 got %h want %h", d, DW'(m_chg)); end
        axi_read(slot_addr(3), d, r);
        n_tests++; if (d !== m_sts[3] || r !== RESP_OKAY) begin n_fail++; $display("FAIL rd_slot3 got %h/%b want %h/00", d, r, m_sts[3]); end
        m_base[3] = m_sts[3];
        m_chg[3]  = 1'b0;
        n_tests++; if (alert !== model_alert()) begin n_fail++; $display("FAIL alert_drop got %b want %b", alert, model_alert()); end
        axi_read(A_CHG, d, r);
        n_tests++; if (d !== DW'(m_chg)) begin n_fail++; $display("FAIL chg_cleared got %h want %h", d, DW'(m_chg)); end
    endtask

    task automatic test_mask();
        logic [DW-1:0] d;
        logic [1:0]    r;
        axi_write(A_MASK, 32'hFFFF_FFF7, 4'hF, r);
        model_mask(32'hFFFF_FFF7, 4'hF);
        n_tests++; if (r !== RESP_OKAY) begin n_fail++; $display("FAIL mask_wr_resp got %b want 00", r); end
        set_slot(3, 32'h1234_5678);
        settle();
        n_tests++; if (alert !== model_alert()) begin n_fail++; $display("FAIL masked_alert got %b want %b", alert, model_alert()); end
        axi_read(A_CHG, d, r);
        n_tests++; if (d !== DW'(m_chg)) begin n_fail++; $display("FAIL masked_chg got %h want %h", d, DW'(m_chg)); end
        axi_read(A_PEND, d, r);
        n_tests++; if (d !== DW'(m_chg & m_mask)) begin n_fail++; $display("FAIL pending got %h want %h", d, DW'(m_chg & m_mask)); end
        axi_write(A_MASK, 32'hFFFF_FFFF, 4'hF, r);
        model_mask(32'hFFFF_FFFF, 4'hF);
        tick(2);
        n_tests++; if (alert !== model_alert()) begin n_fail++; $display("FAIL unmask_alert got %b want %b", alert, model_alert()); end
        axi_read(slot_addr(3), d, r);
        n_tests++; if (d !== m_sts[3]) begin n_fail++; $display("FAIL mask_rd_slot3 got %h want %h", d, m_sts[3]); end
        m_base[3] = m_sts[3];
        m_chg[3]  = 1'b0;
    endtask

    task automatic test_w1c();
        logic [DW-1:0] d;
        logic [1:0]    r;
        // Slot 3 differs from its baseline through the W1C, so the set wins.
        set_slot(3, 32'h0BAD_0003);
        axi_write(A_CHG, 32'h8, 4'hF, r);
        model_w1c(32'h8, 4'hF);
        axi_read(A_CHG, d, r);
        n_tests++; if (d !== DW'(m_chg)) begin n_fail++; $display("FAIL w1c_race got %h want %h", d, DW'(m_chg)); end
        set_slot(5, 32'hDEAD_BEEF);
        settle();
        set_slot(5, m_base[5]);
        settle();
        axi_read(A_CHG, d, r);
        n_tests++; if (d !== DW'(m_chg)) begin n_fail++; $display("FAIL sticky got %h want %h", d, DW'(m_chg)); end
        axi_write(A_CHG, 32'h20, 4'h0, r);
        model_w1c(32'h20, 4'h0);
        axi_read(A_CHG, d, r);
        n_tests++; if (d !== DW'(m_chg)) begin n_fail++; $display("FAIL w1c_nostrb got %h want %h", d, DW'(m_chg)); end
        axi_write(A_CHG, 32'h20, 4'h1, r);
        model_w1c(32'h20, 4'h1);
        axi_read(A_CHG, d, r);
        n_tests++; if (d !== DW'(m_chg)) begin n_fail++; $display("FAIL w1c_clear got %h want %h", d, DW'(m_chg)); end
        axi_read(slot_addr(3), d, r);
        n_tests++; if (d !== m_sts[3]) begin n_fail++; $display("FAIL w1c_rd_slot3 got %h want %h", d, m_sts[3]); end
        m_base[3] = m_sts[3];
        m_chg[3]  = 1'b0;
    endtask

    task automatic test_slverr();
        logic [DW-1:0] d;
        logic [1:0]    r;
        axi_read(slot_addr(N), d, r);
        n_tests++; if (d !== '0 || r !== RESP_SLVERR) begin n_fail++; $display("FAIL rd_idx_n got %h/%b want 0/10", d, r); end
        axi_read(A_BAD, d, r);
        n_tests++; if (d !== '0 || r !== RESP_SLVERR) begin n_fail++; $display("FAIL rd_ctl3 got %h/%b want 0/10", d, r); end
        axi_write(slot_addr(0), 32'hFFFF_FFFF, 4'hF, r);
        n_tests++; if (r !== RESP_SLVERR) begin n_fail++; $display("FAIL wr_slot0 got %b want 10", r); end
        axi_write(A_PEND, 32'h0, 4'hF, r);
        n_tests++; if (r !== RESP_SLVERR) begin n_fail++; $display("FAIL wr_pending got %b want 10", r); end
        axi_read(slot_addr(0), d, r);
        n_tests++; if (d !== m_sts[0] || r !== RESP_OKAY) begin n_fail++; $display("FAIL slot0_kept got %h/%b want %h/00", d, r, m_sts[0]); end
        m_base[0] = m_sts[0];
        m_chg[0]  = 1'b0;
        axi_read(A_MASK, d, r);
        n_tests++; if (d !== DW'(m_mask)) begin n_fail++; $display("FAIL mask_kept got %h want %h", d, DW'(m_mask)); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v;
        logic [1:0]    r;
        int            pulses;
        s_axi.awaddr = A_MASK; s_axi.awvalid = 1'b1; s_axi.bready = 1'b0;
        n_tests++; if (s_axi.awready !== 1'b1) begin n_fail++; $display("FAIL aw_ready got %b want 1", s_axi.awready); end
        tick(1);
        s_axi.awvalid = 1'b0;
        tick(1);
        n_tests++; if (s_axi.awready !== 1'b0 || s_axi.bvalid !== 1'b0) begin n_fail++; $display("FAIL aw_held got %b/%b want 0/0", s_axi.awready, s_axi.bvalid); end
        s_axi.wdata = 32'h0000_FFFF; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        n_tests++; if (s_axi.wready !== 1'b1) begin n_fail++; $display("FAIL w_ready got %b want 1", s_axi.wready); end
        tick(1);
        s_axi.wvalid = 1'b0;
        n_tests++; if (s_axi.bvalid !== 1'b0) begin n_fail++; $display("FAIL b_early got %b want 0", s_axi.bvalid); end
        model_mask(32'h0000_FFFF, 4'hF);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            if (s_axi.bvalid) pulses++;
        end
        n_tests++; if (pulses != 3 || s_axi.bresp !== RESP_OKAY) begin n_fail++; $display("FAIL b_hold got %0d/%b want 3/00", pulses, s_axi.bresp); end
        s_axi.bready = 1'b1;
        tick(1);
        s_axi.bready = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            if (s_axi.bvalid) pulses++;
            tick(1);
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL b_single got %0d extra want 0", pulses); end
        axi_read(A_MASK, v, r);
        n_tests++; if (v !== DW'(m_mask)) begin n_fail++; $display("FAIL b2b_mask got %h want %h", v, DW'(m_mask)); end
        set_slot(7, $urandom);
        settle();
        s_axi.araddr = slot_addr(7); s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
        tick(1);
        s_axi.arvalid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (s_axi.rvalid === 1'b1 && s_axi.rdata === m_sts[7] && s_axi.arready === 1'b0) pulses++;
            tick(1);
        end
        n_tests++; if (pulses != 4) begin n_fail++; $display("FAIL r_stall got %0d stable cycles want 4", pulses); end
        m_base[7] = m_sts[7];
        m_chg[7]  = 1'b0;
        s_axi.rready = 1'b1;
        tick(1);
        s_axi.rready = 1'b0;
        n_tests++; if (s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b1) begin n_fail++; $display("FAIL r_release got %b/%b want 0/1", s_axi.rvalid, s_axi.arready); end
        axi_write(A_MASK, 32'hFFFF_FFFF, 4'hF, r);
        model_mask(32'hFFFF_FFFF, 4'hF);
        tick(2);
        n_tests++; if (alert !== model_alert()) begin n_fail++; $display("FAIL b2b_alert got %b want %b", alert, model_alert()); end
    endtask

    task automatic test_random();
        logic [DW-1:0]   d, v;
        logic [DW/8-1:0] s;
        logic [1:0]      r;
        int              op, k, idx;
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0: begin
                    k = int'($urandom_range(1, 4));
                    for (int j = 0; j < k; j++) begin
                        idx = int'($urandom_range(0, N - 1));
                        v = ($urandom_range(0, 3) == 0) ? m_base[idx] : $urandom;
                        set_slot(idx, v);
                    end
                    settle();
                end
                1: begin
                    idx = int'($urandom_range(0, N - 1));
                    axi_read(slot_addr(idx), d, r);
                    n_tests++; if (d !== m_sts[idx] || r !== RESP_OKAY) begin n_fail++; $display("FAIL rnd_slot%0d got %h/%b want %h/00", idx, d, r, m_sts[idx]); end
                    m_base[idx] = m_sts[idx];
                    m_chg[idx]  = 1'b0;
                end
                2: begin
                    v = $urandom;
                    s = DW/8'($urandom);
                    axi_write(A_CHG, v, s, r);
                    model_w1c(v, s);
                    axi_read(A_CHG, d, r);
                    n_tests++; if (d !== DW'(m_chg)) begin n_fail++; $display("FAIL rnd_w1c got %h want %h", d, DW'(m_chg)); end
                end
                3: begin
                    v = $urandom;
                    s = DW/8'($urandom);
                    axi_write(A_MASK, v, s, r);
                    model_mask(v, s);
                    axi_read(A_MASK, d, r);
                    n_tests++; if (d !== DW'(m_mask)) begin n_fail++; $display("FAIL rnd_mask got %h want %h", d, DW'(m_mask)); end
                end
                default: begin
                    axi_read(A_PEND, d, r);
                    n_tests++; if (d !== DW'(m_chg & m_mask)) begin n_fail++; $display("FAIL rnd_pending got %h want %h", d, DW'(m_chg & m_mask)); end
                end
            endcase
            tick(2);
            n_tests++; if (alert !== model_alert()) begin n_fail++; $display("FAIL rnd_alert it=%0d got %b want %b", it, alert, model_alert()); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alert_latency();
        test_mask();
        test_w1c();
        test_slverr();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
